// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, control aliases and state encoding for the serial ALU
package alu_pkg;

  // operation field, ctrl[1:0]
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  // full control words {A_invert, B_invert, operation}
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_bit_eval.sv
// rtl/alu_bit_eval.sv - combinational evaluation of one ALU bit position
module alu_bit_eval
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       carry,
  input  logic [1:0] op,
  output logic       res_bit,
  output logic       p,
  output logic       g,
  output logic       eq,
  output logic       sum
);

  // a and b arrive already inverted; SLT writes 0 here and bit 0 is patched at the MSB
  always_comb begin
    p   = a | b;
    g   = a & b;
    eq  = a ^ b;
    sum = eq ^ carry;
    case (op)
      OP_AND:  res_bit = g;
      OP_OR:   res_bit = p;
      OP_ADD:  res_bit = sum;
      default: res_bit = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - bit-serial ALU engine with valid/ready operand and result handshakes
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [3:0]       ctrl_q;
  logic             carry;
  logic [WIDTH-1:0] acc;
  logic             ovf_q;
  logic             cout_q;

  logic             a_bit;
  logic             b_bit;
  logic             res_bit;
  logic             p_bit;
  logic             g_bit;
  logic             eq_unused;
  logic             sum_bit;
  logic             c_next;
  logic             last;
  logic             msb_ovf;
  logic [WIDTH-1:0] acc_next;

  // operand shadows shift right, so the current bit always sits at position 0
  assign a_bit = ctrl_q[3] ^ a_sh[0];
  assign b_bit = ctrl_q[2] ^ b_sh[0];

  alu_bit_eval u_bit (
    .a       (a_bit),
    .b       (b_bit),
    .carry   (carry),
    .op      (ctrl_q[1:0]),
    .res_bit (res_bit),
    .p       (p_bit),
    .g       (g_bit),
    .eq      (eq_unused),
    .sum     (sum_bit)
  );

  // carry chain, MSB overflow and the assembled word including the SLT bit-0 patch
  always_comb begin
    c_next   = g_bit | (p_bit & carry);
    last     = (cnt == CNT_W'(WIDTH - 1));
    msb_ovf  = carry ^ c_next;
    acc_next = {res_bit, acc[WIDTH-1:1]};
    if (last && (ctrl_q[1:0] == OP_SLT)) begin
      // after this shift the earlier bit-0 slot lands at position 0
      acc_next[0] = sum_bit ^ msb_ovf;
    end
  end

  // sequencing FSM: accept, one bit per cycle, publish on the first DONE cycle, hand off
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      ctrl_q     <= '0;
      carry      <= 1'b0;
      acc        <= '0;
      ovf_q      <= 1'b0;
      cout_q     <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= src1_i;
            b_sh     <= src2_i;
            ctrl_q   <= ctrl_i;
            carry    <= ctrl_i[2];
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          acc   <= acc_next;
          carry <= c_next;
          if (last) begin
            cout_q <= c_next;
            ovf_q  <= ctrl_q[1] ? msb_ovf : 1'b0;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (!out_valid) begin
            result_o   <= acc;
            zero_o     <= (acc == '0);
            cout_o     <= cout_q;
            overflow_o <= ovf_q;
            out_valid  <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb/tb_alu_serial_seq.sv - self-checking bench for the bit-serial ALU engine
module tb_alu_serial_seq;

  localparam int WIDTH = 32;
  localparam int MAXWAIT = 200;

  logic             clk_i;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [3:0]       ctrl_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             cout_o;
  logic             overflow_o;

  int total;
  int bad;

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
    .ctrl_i     (ctrl_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_o   (result_o),
    .zero_o     (zero_o),
    .cout_o     (cout_o),
    .overflow_o (overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // word-level reference: invert, add with carry-in B_invert, signed overflow from sign bits
  function automatic void ref_model(input logic [31:0] s1, input logic [31:0] s2, input logic [3:0] c,
                                    output logic [31:0] r, output logic z, output logic co, output logic ov);
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] full;
    logic        sov;
    a    = c[3] ? ~s1 : s1;
    b    = c[2] ? ~s2 : s2;
    full = {1'b0, a} + {1'b0, b} + {32'd0, c[2]};
    co   = full[32];
    sov  = (a[31] == b[31]) && (full[31] != a[31]);
    case (c[1:0])
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = full[31:0];
      default: r = {31'd0, full[31] ^ sov};
    endcase
    ov = c[1] ? sov : 1'b0;
    z  = (r == 32'd0);
  endfunction

  // present one bundle, scramble inputs after acceptance, wait for out_valid
  task automatic run_txn(input logic [31:0] s1, input logic [31:0] s2, input logic [3:0] c,
                         output logic [31:0] r, output logic z, output logic co, output logic ov,
                         output int lat);
    @(negedge clk_i);
    src1_i   = s1;
    src2_i   = s2;
    ctrl_i   = c;
    in_valid = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid = 1'b0;
    src1_i   = $urandom;
    src2_i   = $urandom;
    ctrl_i   = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < MAXWAIT) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    r  = result_o;
    z  = zero_o;
    co = cout_o;
    ov = overflow_o;
  endtask

  task automatic release_txn();
    @(negedge clk_i);
    out_ready = 1'b1;
    @(posedge clk_i);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (result_o !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result_o); end
    total++; if ({zero_o, cout_o, overflow_o} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b want=000", {zero_o, cout_o, overflow_o});
    end
  endtask

  task automatic test_directed();
    logic [31:0] vs1 [9];
    logic [31:0] vs2 [9];
    logic [3:0]  vc  [9];
    logic [31:0] vres[9];
    logic [31:0] r, er;
    logic        z, co, ov, ez, eco, eov;
    int          lat;
    vs1[0] = 32'd7;          vs2[0] = 32'd5;          vc[0] = 4'b0010; vres[0] = 32'd12;
    vs1[1] = 32'd5;          vs2[1] = 32'd7;          vc[1] = 4'b0110; vres[1] = 32'hFFFF_FFFE;
    vs1[2] = 32'd7;          vs2[2] = 32'd7;          vc[2] = 4'b0110; vres[2] = 32'd0;
    vs1[3] = 32'h8000_0000;  vs2[3] = 32'd1;          vc[3] = 4'b0111; vres[3] = 32'd1;
    vs1[4] = 32'h7FFF_FFFF;  vs2[4] = 32'hFFFF_FFFF;  vc[4] = 4'b0111; vres[4] = 32'd0;
    vs1[5] = 32'h7FFF_FFFF;  vs2[5] = 32'd1;          vc[5] = 4'b0010; vres[5] = 32'h8000_0000;
    vs1[6] = 32'hF0F0_F0F0;  vs2[6] = 32'h0F0F_0F00;  vc[6] = 4'b1100; vres[6] = 32'h0000_000F;
    vs1[7] = 32'hFFFF_FFFF;  vs2[7] = 32'd1;          vc[7] = 4'b0010; vres[7] = 32'd0;
    vs1[8] = 32'hA5A5_0000;  vs2[8] = 32'h0000_5A5A;  vc[8] = 4'b0001; vres[8] = 32'hA5A5_5A5A;
    for (int i = 0; i < 9; i++) begin
      run_txn(vs1[i], vs2[i], vc[i], r, z, co, ov, lat);
      ref_model(vs1[i], vs2[i], vc[i], er, ez, eco, eov);
      total++; if (lat !== WIDTH + 1) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, WIDTH + 1); end
      total++; if (r !== vres[i]) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", i, r, vres[i]); end
      total++; if (z !== ez) begin bad++; $display("FAIL dir%0d_zero got=%b want=%b", i, z, ez); end
      total++; if (co !== eco) begin bad++; $display("FAIL dir%0d_cout got=%b want=%b", i, co, eco); end
      total++; if (ov !== eov) begin bad++; $display("FAIL dir%0d_overflow got=%b want=%b", i, ov, eov); end
      release_txn();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++; $display("FAIL dir%0d_handoff got ov=%b ir=%b want 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] s1, s2, r, er;
    logic [3:0]  c;
    logic        z, co, ov, ez, eco, eov;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      s1 = $urandom;
      s2 = (i % 4 == 0) ? s1 : 32'($urandom);
      c  = (i < 16) ? 4'(i) : 4'($urandom);
      run_txn(s1, s2, c, r, z, co, ov, lat);
      ref_model(s1, s2, c, er, ez, eco, eov);
      total++; if (lat !== WIDTH + 1) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, WIDTH + 1); end
      total++; if ({r, z, co, ov} !== {er, ez, eco, eov}) begin
        bad++; $display("FAIL rnd%0d ctrl=%b s1=%h s2=%h got r=%h z=%b c=%b v=%b want r=%h z=%b c=%b v=%b",
                        i, c, s1, s2, r, z, co, ov, er, ez, eco, eov);
      end
      release_txn();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, er;
    logic        z, co, ov, ez, eco, eov;
    int          lat;
    run_txn(32'h1234_5678, 32'h0000_1111, 4'b0010, r, z, co, ov, lat);
    ref_model(32'h1234_5678, 32'h0000_1111, 4'b0010, er, ez, eco, eov);
    total++; if (r !== er) begin bad++; $display("FAIL bp_first_result got=%h want=%h", r, er); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      in_valid = (k >= 3 && k < 7);
      src1_i   = 32'hDEAD_BEEF;
      src2_i   = 32'h0BAD_F00D;
      ctrl_i   = 4'b0110;
      @(posedge clk_i);
      #1;
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got ov=%b ir=%b want 1 0", k, out_valid, in_ready);
      end
      total++; if ({result_o, zero_o, cout_o, overflow_o} !== {er, ez, eco, eov}) begin
        bad++; $display("FAIL bp_stable%0d got r=%h want r=%h", k, result_o, er);
      end
    end
    @(negedge clk_i);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    src1_i    = 32'd100;
    src2_i    = 32'd58;
    ctrl_i    = 4'b0110;
    @(posedge clk_i);
    #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release got ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk_i);
    #1;
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_accept got ir=%b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < MAXWAIT) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    ref_model(32'd100, 32'd58, 4'b0110, er, ez, eco, eov);
    total++; if (lat !== WIDTH + 1) begin bad++; $display("FAIL bp_next_latency got=%0d want=%0d", lat, WIDTH + 1); end
    total++; if (result_o !== er || er !== 32'd42) begin bad++; $display("FAIL bp_next_result got=%h want=%h", result_o, 32'd42); end
    release_txn();
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] r;
    logic        z, co, ov;
    int          lat;
    @(negedge clk_i);
    src1_i   = 32'hFFFF_0000;
    src2_i   = 32'h0000_FFFF;
    ctrl_i   = 4'b0001;
    in_valid = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk_i);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_hs got ir=%b ov=%b want 1 0", in_ready, out_valid);
    end
    total++; if ({result_o, zero_o, cout_o, overflow_o} !== 35'd0) begin
      bad++; $display("FAIL rst_mid_outputs got r=%h z=%b c=%b v=%b want all 0", result_o, zero_o, cout_o, overflow_o);
    end
    @(negedge clk_i);
    rst_n = 1'b1;
    for (int k = 0; k < WIDTH + 4; k++) begin
      @(posedge clk_i);
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_no_pulse%0d got=%b want=0", k, out_valid); end
    end
    run_txn(32'd3, 32'd4, 4'b0010, r, z, co, ov, lat);
    total++; if (lat !== WIDTH + 1) begin bad++; $display("FAIL rst_after_latency got=%0d want=%0d", lat, WIDTH + 1); end
    total++; if ({r, z, co, ov} !== {32'd7, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL rst_after_add got r=%h z=%b c=%b v=%b want r=7 z=0 c=0 v=0", r, z, co, ov);
    end
    release_txn();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    src1_i    = '0;
    src2_i    = '0;
    ctrl_i    = '0;
    repeat (3) @(negedge clk_i);
    test_reset();
    rst_n = 1'b1;
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
